instruction_fetch_unit: RTL and testbench

Front-end stage directly upstream of the decode/control stage. Holds the PC and issues word reads to instruction memory over the busywait handshake. Buffers fetched words, each with its PC, in a small prefetch FIFO. Presents one instruction per cycle to decode, honours decode stalls, and redirects on taken branches/jumps resolved downstream.

---
 rtl/instruction_fetch_unit_pkg.sv | 17 +
 rtl/ifu_prefetch_fifo.sv | 47 ++++
 rtl/instruction_fetch_unit.sv | 107 ++++++++++
 tb/tb_instruction_fetch_unit.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: fetch FSM encoding, PC step and NOP word.
package instruction_fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_t;

  localparam logic [31:0] PC_INC   = 32'd4;
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/ifu_prefetch_fifo.sv
// Prefetch FIFO of {PC, word} entries with push/pop/flush; FIFO_DEPTH must be a power of two.
module ifu_prefetch_fifo #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  logic                        pop,
  input  logic                        flush,
  input  logic [63:0]                 wdata,
  output logic [63:0]                 rdata,
  output logic [$clog2(FIFO_DEPTH):0] count
);
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [63:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  assign rdata = (count != '0) ? mem[rd_ptr] : 64'd0;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch front end: PC/busywait handshake FSM feeding a prefetch FIFO to decode.
// Optional IFU_PERF_COUNTERS_EN adds FETCH_COUNT and BUBBLE_COUNT outputs.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  output logic        IMEM_READ,
  output logic [31:0] IMEM_ADDRESS,
  input  logic [31:0] IMEM_READDATA,
  input  logic        IMEM_BUSYWAIT,
  output logic [31:0] INSTRUCTION,
  output logic [31:0] INSTR_PC,
  output logic        INSTR_VALID,
  input  logic        DECODE_STALL,
  input  logic        BRANCH_TAKEN,
  input  logic [31:0] BRANCH_TARGET
`ifdef IFU_PERF_COUNTERS_EN
  ,
  output logic [31:0] FETCH_COUNT,
  output logic [31:0] BUBBLE_COUNT
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  fetch_state_t  state, state_nxt;
  logic [31:0]   pc;
  logic [31:0]   drain_addr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_after;
  logic [63:0]   head;
  logic          complete, push, pop;

  assign IMEM_READ    = (state != ST_IDLE);
  assign IMEM_ADDRESS = (state == ST_DRAIN) ? drain_addr : pc;
  assign complete     = IMEM_READ & ~IMEM_BUSYWAIT;
  // A redirect overrides both ends of the FIFO: the completing word is dropped and nothing pops.
  assign push         = (state == ST_FETCH) & complete & ~BRANCH_TAKEN;
  assign pop          = INSTR_VALID & ~DECODE_STALL & ~BRANCH_TAKEN;
  assign INSTR_VALID  = (count != '0);
  assign {INSTR_PC, INSTRUCTION} = head;

  ifu_prefetch_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (CLK),
    .rst   (RESET),
    .push  (push),
    .pop   (pop),
    .flush (BRANCH_TAKEN),
    .wdata ({pc, IMEM_READDATA}),
    .rdata (head),
    .count (count)
  );

  always_comb begin
    count_after = count;
    if (push && !pop)      count_after = count + CW'(1);
    else if (pop && !push) count_after = count - CW'(1);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (BRANCH_TAKEN || (count < DEPTH_C)) state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        if (BRANCH_TAKEN)  state_nxt = complete ? ST_FETCH : ST_DRAIN;
        else if (complete) state_nxt = (count_after < DEPTH_C) ? ST_FETCH : ST_IDLE;
      end
      ST_DRAIN: begin
        if (complete) state_nxt = ST_FETCH;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state      <= ST_IDLE;
      pc         <= RESET_PC;
      drain_addr <= RESET_PC;
    end else begin
      state <= state_nxt;
      if (BRANCH_TAKEN)  pc <= align_word(BRANCH_TARGET);
      else if (push)     pc <= pc + PC_INC;
      // The abandoned request keeps its address on the bus until memory finishes it.
      if ((state == ST_FETCH) && BRANCH_TAKEN && !complete) drain_addr <= pc;
    end
  end

`ifdef IFU_PERF_COUNTERS_EN
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      FETCH_COUNT  <= 32'd0;
      BUBBLE_COUNT <= 32'd0;
    end else begin
      if (push)         FETCH_COUNT  <= FETCH_COUNT + 32'd1;
      if (!INSTR_VALID) BUBBLE_COUNT <= BUBBLE_COUNT + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: memory returns address ^ NOP_WORD, monitor checks accepted instructions.
module tb_instruction_fetch_unit;
  import instruction_fetch_unit_pkg::*;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        IMEM_READ;
  logic [31:0] IMEM_ADDRESS;
  logic [31:0] IMEM_READDATA;
  logic        IMEM_BUSYWAIT;
  logic [31:0] INSTRUCTION;
  logic [31:0] INSTR_PC;
  logic        INSTR_VALID;
  logic        DECODE_STALL = 1'b0;
  logic        BRANCH_TAKEN = 1'b0;
  logic [31:0] BRANCH_TARGET = 32'd0;
`ifdef IFU_PERF_COUNTERS_EN
  logic [31:0] FETCH_COUNT;
  logic [31:0] BUBBLE_COUNT;
`endif

  instruction_fetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(2)) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .IMEM_READ     (IMEM_READ),
    .IMEM_ADDRESS  (IMEM_ADDRESS),
    .IMEM_READDATA (IMEM_READDATA),
    .IMEM_BUSYWAIT (IMEM_BUSYWAIT),
    .INSTRUCTION   (INSTRUCTION),
    .INSTR_PC      (INSTR_PC),
    .INSTR_VALID   (INSTR_VALID),
    .DECODE_STALL  (DECODE_STALL),
    .BRANCH_TAKEN  (BRANCH_TAKEN),
    .BRANCH_TARGET (BRANCH_TARGET)
`ifdef IFU_PERF_COUNTERS_EN
    ,
    .FETCH_COUNT   (FETCH_COUNT),
    .BUBBLE_COUNT  (BUBBLE_COUNT)
`endif
  );

  always #5 CLK = ~CLK;

  // Memory model: each access is busy for 'lat' cycles, then completes.
  int lat = 0;
  int wait_cnt = 0;
  assign IMEM_BUSYWAIT = IMEM_READ && (wait_cnt < lat);
  assign IMEM_READDATA = IMEM_ADDRESS ^ NOP_WORD;
  always @(posedge CLK) begin
    if (!IMEM_READ || !IMEM_BUSYWAIT) wait_cnt <= 0;
    else                              wait_cnt <= wait_cnt + 1;
  end

  logic [31:0] exp_q[$];
  logic [31:0] mon_e;
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (!RESET && INSTR_VALID && !DECODE_STALL && !BRANCH_TAKEN) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_instr: got pc %h expected none", INSTR_PC);
      end else begin
        mon_e = exp_q.pop_front();
        check("instr_pc", INSTR_PC, mon_e);
        check("instruction", INSTRUCTION, mon_e ^ NOP_WORD);
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    BRANCH_TAKEN = 1'b0;
    #1;
    exp_q.delete();
    check("rst_read", IMEM_READ, 0);
    check("rst_valid", INSTR_VALID, 0);
    check("rst_instr", INSTRUCTION, 0);
    check("rst_pc", INSTR_PC, 0);
`ifdef IFU_PERF_COUNTERS_EN
    check("rst_fetch_count", FETCH_COUNT, 0);
    check("rst_bubble_count", BUBBLE_COUNT, 0);
`endif
    repeat (2) tick();
    RESET = 1'b0;
  endtask

  task automatic wait_drain(input int budget, input logic stall_after);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d entries left, expected 0", exp_q.size());
      exp_q.delete();
    end
    if (stall_after) DECODE_STALL = 1'b1;
  endtask

  task automatic wait_addr(input logic [31:0] a, input int budget);
    int n = 0;
    while (!(IMEM_READ && IMEM_ADDRESS == a) && n < budget) begin
      tick();
      n++;
    end
    check("wait_addr", IMEM_ADDRESS, a);
  endtask

  initial begin
    #3;
    // Zero-wait streaming, then stall until full and release.
    lat = 0; DECODE_STALL = 1'b0;
    do_reset();
    for (int i = 0; i < 5; i++) exp_q.push_back(32'(i * 4));
    tick(); check("a_read0", IMEM_READ, 1); check("a_addr0", IMEM_ADDRESS, 32'h0);
    tick(); check("a_addr1", IMEM_ADDRESS, 32'h4);
    tick(); check("a_addr2", IMEM_ADDRESS, 32'h8);
    wait_drain(40, 1'b1);
    repeat (5) tick();
    check("stall_read", IMEM_READ, 0);
    check("stall_valid", INSTR_VALID, 1);
    check("stall_head_pc", INSTR_PC, 32'h14);
    check("stall_head_instr", INSTRUCTION, 32'h14 ^ NOP_WORD);
    exp_q.push_back(32'h14); exp_q.push_back(32'h18); exp_q.push_back(32'h1C);
    DECODE_STALL = 1'b0;
    wait_drain(40, 1'b1);

    // Three busywait cycles per access; redirect during the 2nd busy cycle at 0x8.
    lat = 3; DECODE_STALL = 1'b0;
    do_reset();
    exp_q.push_back(32'h0); exp_q.push_back(32'h4);
    tick();
    for (int i = 0; i < 4; i++) begin
      check("busy_read", IMEM_READ, 1);
      check("busy_addr", IMEM_ADDRESS, 32'h0);
      tick();
    end
    check("busy_next_addr", IMEM_ADDRESS, 32'h4);
    wait_addr(32'h8, 40);
    tick();
    check("pre_branch_q", exp_q.size(), 0);
    BRANCH_TAKEN = 1'b1; BRANCH_TARGET = 32'h100;
    tick();
    BRANCH_TAKEN = 1'b0;
    check("drain_valid", INSTR_VALID, 0);
    check("drain_read", IMEM_READ, 1);
    check("drain_addr", IMEM_ADDRESS, 32'h8);
    exp_q.push_back(32'h100); exp_q.push_back(32'h104);
    wait_addr(32'h100, 20);
    wait_drain(40, 1'b1);

    // Redirect to unaligned 0x203 while a zero-wait fetch completes.
    lat = 0; DECODE_STALL = 1'b0;
    do_reset();
    exp_q.push_back(32'h0); exp_q.push_back(32'h4);
    wait_drain(40, 1'b0);
    BRANCH_TAKEN = 1'b1; BRANCH_TARGET = 32'h203;
    exp_q.push_back(32'h200); exp_q.push_back(32'h204);
    tick();
    BRANCH_TAKEN = 1'b0;
    check("c_addr", IMEM_ADDRESS, 32'h200);
    check("c_read", IMEM_READ, 1);
    check("c_valid", INSTR_VALID, 0);
    wait_drain(40, 1'b1);

    // Redirect from IDLE to the top of the address space; PC wraps to 0.
    lat = 0; DECODE_STALL = 1'b1;
    do_reset();
    repeat (4) tick();
    check("full_read", IMEM_READ, 0);
    check("full_valid", INSTR_VALID, 1);
    BRANCH_TAKEN = 1'b1; BRANCH_TARGET = 32'hFFFF_FFFF;
    exp_q.push_back(32'hFFFF_FFFC); exp_q.push_back(32'h0); exp_q.push_back(32'h4);
    tick();
    BRANCH_TAKEN = 1'b0;
    check("wrap_valid", INSTR_VALID, 0);
    check("wrap_addr", IMEM_ADDRESS, 32'hFFFF_FFFC);
    check("wrap_read", IMEM_READ, 1);
    DECODE_STALL = 1'b0;
    wait_drain(40, 1'b1);

    // Reset asserted in the middle of a busywait with an entry buffered.
    lat = 3; DECODE_STALL = 1'b1;
    do_reset();
    wait_addr(32'h4, 20);
    tick();
    check("e_pre_valid", INSTR_VALID, 1);
    check("e_pre_read", IMEM_READ, 1);
    RESET = 1'b1;
    #1;
    check("e_rst_read", IMEM_READ, 0);
    check("e_rst_valid", INSTR_VALID, 0);
    lat = 0; DECODE_STALL = 1'b0;
    do_reset();
    exp_q.push_back(32'h0); exp_q.push_back(32'h4);
    tick();
    check("e_resume_read", IMEM_READ, 1);
    check("e_resume_addr", IMEM_ADDRESS, 32'h0);
    wait_drain(40, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
